ifid_hazard_ctrl: RTL and testbench

- Pipeline control unit that sequences the IF/ID pipeline register and the PC register.
- Generates STALL, FLUSH and bubble controls from four sources: load-use hazards, branch mispredicts, I-cache misses and D-memory busy.
- Sits beside the IF and ID stages. Its outputs drive the STALL and FLUSH inputs of the IF/ID register, the PC-update enable and the ID/EX bubble insert.
- Keeps saturating stall and flush event counters for debug.

---
 rtl/ifid_hazard_ctrl_pkg.sv | 27 ++
 rtl/ifid_hazard_ctrl_if.sv | 55 +++++
 rtl/ifid_hazard_ctrl_sat_counter.sv | 30 +++
 rtl/ifid_hazard_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_ifid_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ifid_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ifid_hazard_ctrl_pkg
// Shared front-end pipeline definitions for the IF/ID hazard controller:
//   state_t    - controller FSM states
//   REG_ZERO   - architectural zero register (never a real hazard source)
//   NOP_INSTR  - encoding the IF/ID register holds after a flush
//   reg_match  - "this source operand reads that destination" helper
// ---------------------------------------------------------------------------
package ifid_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LOAD_USE = 2'd1,
        IMISS    = 2'd2
    } state_t;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // True when an operand that is actually read names the given register.
    function automatic logic reg_match(input logic       uses,
                                       input logic [4:0] src,
                                       input logic [4:0] dst);
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/ifid_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// ifid_hazard_ctrl_if
// Bundles the hazard sources (ID operands, EX load, branch resolution,
// I-cache and D-memory status) and the pipeline controls / debug counters
// produced by ifid_hazard_ctrl.
//   master : pipeline side, drives hazard sources, receives controls
//   slave  : controller side
// Handshake note: there is no valid/ready flow here; every input is a
// level sampled each cycle, BR_Mispredict is only meaningful with BR_Valid,
// and every control output is a same-cycle level consumed at the next edge.
// ---------------------------------------------------------------------------
interface ifid_hazard_ctrl_if
    import ifid_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_UsesRs;
    logic             ID_UsesRt;
    logic             EX_MemRead;
    logic [4:0]       EX_Rd;
    logic             BR_Valid;
    logic             BR_Mispredict;
    logic [31:0]      BR_Target;
    logic             IC_Miss;
    logic             IC_Ready;
    logic             DMEM_Busy;

    logic             STALL_PC;
    logic             STALL_IFID;
    logic             FLUSH_IFID;
    logic             BUBBLE_IDEX;
    logic             PC_Redirect_Valid;
    logic [31:0]      PC_Redirect;
    logic             Miss_Timeout_ERR;
    logic [CNT_W-1:0] Stall_Count;
    logic [CNT_W-1:0] Flush_Count;
    state_t           fsm_state;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, EX_MemRead, EX_Rd,
               BR_Valid, BR_Mispredict, BR_Target, IC_Miss, IC_Ready, DMEM_Busy,
        input  STALL_PC, STALL_IFID, FLUSH_IFID, BUBBLE_IDEX, PC_Redirect_Valid,
               PC_Redirect, Miss_Timeout_ERR, Stall_Count, Flush_Count, fsm_state
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, EX_MemRead, EX_Rd,
               BR_Valid, BR_Mispredict, BR_Target, IC_Miss, IC_Ready, DMEM_Busy,
        output STALL_PC, STALL_IFID, FLUSH_IFID, BUBBLE_IDEX, PC_Redirect_Valid,
               PC_Redirect, Miss_Timeout_ERR, Stall_Count, Flush_Count, fsm_state
    );

endinterface

// File: rtl/ifid_hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// ifid_hazard_ctrl_sat_counter
// Up-counter that stops at MAX (all-ones by default) instead of wrapping.
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   clear    : synchronous clear, wins over inc
//   inc      : count up by one at this edge unless already at MAX
//   count    : current value
// ---------------------------------------------------------------------------
module ifid_hazard_ctrl_sat_counter #(
    parameter int           W   = 32,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ifid_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// ifid_hazard_ctrl
// Front-end pipeline sequencer. Combines load-use hazards, branch
// mispredicts, I-cache misses and D-memory back-pressure into the IF/ID
// stall/flush, PC hold/redirect and ID/EX bubble controls. Controls are
// combinational so the pipeline registers act at the same clock edge.
// Priority every cycle: mispredict > DMEM_Busy > load-use > I-miss > run.
//   CLK, RESET : clock, asynchronous active-high reset
//   bus        : ifid_hazard_ctrl_if slave (hazard sources in, controls,
//                sticky miss-timeout error, stall/flush counters and the
//                FSM state for debug out)
// ---------------------------------------------------------------------------
module ifid_hazard_ctrl
    import ifid_hazard_ctrl_pkg::*;
#(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int MISS_TIMEOUT    = 255,
    parameter int CNT_W           = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    ifid_hazard_ctrl_if.slave bus
);

    localparam logic [3:0]  LU_INIT = 4'(LOAD_USE_CYCLES - 1);
    localparam logic [15:0] TO_MAX  = 16'(MISS_TIMEOUT);
    // tcnt value during the wait cycle whose edge reaches the timeout.
    localparam logic [15:0] TO_LAST = 16'(MISS_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [3:0]  lu_cnt_q, lu_cnt_d;
    logic [15:0] tcnt;
    logic        tcnt_clear;
    logic        err_q, err_set;
    logic [31:0] redirect_q;

    logic        lu_hz, mp;
    logic        stall_pc, stall_ifid, flush_ifid, bubble_idex, redirect_v;
    logic        stall_pc_o, stall_ifid_o, flush_ifid_o, bubble_idex_o, redirect_v_o;
    logic [CNT_W-1:0] stall_count, flush_count;

    assign lu_hz = bus.EX_MemRead && (bus.EX_Rd != REG_ZERO) &&
                   (reg_match(bus.ID_UsesRs, bus.ID_Rs, bus.EX_Rd) ||
                    reg_match(bus.ID_UsesRt, bus.ID_Rt, bus.EX_Rd));
    assign mp    = bus.BR_Valid && bus.BR_Mispredict;

    // -----------------------------------------------------------------------
    // Next state and raw controls
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        lu_cnt_d    = lu_cnt_q;
        tcnt_clear  = 1'b0;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        redirect_v  = 1'b0;

        if (mp) begin
            // Wrong-path fetch is discarded whatever we were waiting on.
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
            redirect_v  = 1'b1;
            state_d     = RUN;
        end else if (bus.DMEM_Busy) begin
            // Freeze: state and load-use count hold, no bubble.
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (lu_hz) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                        if (LOAD_USE_CYCLES > 1) begin
                            state_d  = LOAD_USE;
                            lu_cnt_d = LU_INIT;
                        end
                    end else if (bus.IC_Miss) begin
                        // Hold PC, send a bubble into ID while refilling.
                        stall_pc   = 1'b1;
                        flush_ifid = 1'b1;
                        tcnt_clear = 1'b1;
                        state_d    = IMISS;
                    end
                end
                LOAD_USE: begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    if (lu_cnt_q <= 4'd1) begin
                        state_d = RUN;
                    end else begin
                        lu_cnt_d = lu_cnt_q - 4'd1;
                    end
                end
                IMISS: begin
                    if (bus.IC_Ready) begin
                        // Refill done: the miss controls drop this cycle; a
                        // coexisting load-use is then handled as from RUN.
                        state_d = RUN;
                        if (lu_hz) begin
                            stall_pc    = 1'b1;
                            stall_ifid  = 1'b1;
                            bubble_idex = 1'b1;
                            if (LOAD_USE_CYCLES > 1) begin
                                state_d  = LOAD_USE;
                                lu_cnt_d = LU_INIT;
                            end
                        end
                    end else begin
                        stall_pc   = 1'b1;
                        flush_ifid = 1'b1;
                        // Load-use bubble is ORed in; the IF/ID stall it
                        // would add is overridden by the flush below.
                        if (lu_hz) begin
                            stall_ifid  = 1'b1;
                            bubble_idex = 1'b1;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Timeout runs through DMEM freezes but not across a mispredict or a
    // cycle that actually leaves IMISS on IC_Ready.
    assign err_set = (state_q == IMISS) && !mp &&
                     !(bus.IC_Ready && !bus.DMEM_Busy) && (tcnt >= TO_LAST);

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= RUN;
            lu_cnt_q   <= '0;
            err_q      <= 1'b0;
            redirect_q <= '0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (mp) begin
                redirect_q <= bus.BR_Target;
            end
        end
    end

    ifid_hazard_ctrl_sat_counter #(
        .W   (16),
        .MAX (TO_MAX)
    ) u_tcnt (
        .clk   (CLK),
        .rst   (RESET),
        .clear (tcnt_clear),
        .inc   (state_q == IMISS),
        .count (tcnt)
    );

    // -----------------------------------------------------------------------
    // Outputs: forced quiet while RESET is high; flush always beats stall.
    // -----------------------------------------------------------------------
    assign stall_pc_o    = stall_pc    && !RESET;
    assign flush_ifid_o  = flush_ifid  && !RESET;
    assign stall_ifid_o  = stall_ifid  && !flush_ifid && !RESET;
    assign bubble_idex_o = bubble_idex && !RESET;
    assign redirect_v_o  = redirect_v  && !RESET;

    ifid_hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst   (RESET),
        .clear (1'b0),
        .inc   (stall_pc_o),
        .count (stall_count)
    );

    ifid_hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .rst   (RESET),
        .clear (1'b0),
        .inc   (flush_ifid_o),
        .count (flush_count)
    );

    assign bus.STALL_PC          = stall_pc_o;
    assign bus.STALL_IFID        = stall_ifid_o;
    assign bus.FLUSH_IFID        = flush_ifid_o;
    assign bus.BUBBLE_IDEX       = bubble_idex_o;
    assign bus.PC_Redirect_Valid = redirect_v_o;
    assign bus.PC_Redirect       = redirect_v_o ? bus.BR_Target : redirect_q;
    assign bus.Miss_Timeout_ERR  = err_q;
    assign bus.Stall_Count       = stall_count;
    assign bus.Flush_Count       = flush_count;
    assign bus.fsm_state         = state_q;

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ifid_hazard_ctrl
// Two controllers share one stimulus stream:
//   dut_a : LOAD_USE_CYCLES=1, MISS_TIMEOUT=4,   CNT_W=4
//   dut_b : LOAD_USE_CYCLES=2, MISS_TIMEOUT=255, CNT_W=32
// Inputs change just after a posedge; combinational controls are sampled
// 1 ns later, registered values 1 ns after the following posedge.
// ---------------------------------------------------------------------------
module tb_ifid_hazard_ctrl;
    import ifid_hazard_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, ex_mem_read;
    logic        br_valid, br_mispredict;
    logic [31:0] br_target;
    logic        ic_miss, ic_ready, dmem_busy;

    int vectors     = 0;
    int miscompares = 0;

    ifid_hazard_ctrl_if #(.CNT_W(4))  if_a ();
    ifid_hazard_ctrl_if #(.CNT_W(32)) if_b ();

    assign if_a.ID_Rs = id_rs;          assign if_b.ID_Rs = id_rs;
    assign if_a.ID_Rt = id_rt;          assign if_b.ID_Rt = id_rt;
    assign if_a.ID_UsesRs = id_uses_rs; assign if_b.ID_UsesRs = id_uses_rs;
    assign if_a.ID_UsesRt = id_uses_rt; assign if_b.ID_UsesRt = id_uses_rt;
    assign if_a.EX_MemRead = ex_mem_read; assign if_b.EX_MemRead = ex_mem_read;
    assign if_a.EX_Rd = ex_rd;          assign if_b.EX_Rd = ex_rd;
    assign if_a.BR_Valid = br_valid;    assign if_b.BR_Valid = br_valid;
    assign if_a.BR_Mispredict = br_mispredict; assign if_b.BR_Mispredict = br_mispredict;
    assign if_a.BR_Target = br_target;  assign if_b.BR_Target = br_target;
    assign if_a.IC_Miss = ic_miss;      assign if_b.IC_Miss = ic_miss;
    assign if_a.IC_Ready = ic_ready;    assign if_b.IC_Ready = ic_ready;
    assign if_a.DMEM_Busy = dmem_busy;  assign if_b.DMEM_Busy = dmem_busy;

    ifid_hazard_ctrl #(.LOAD_USE_CYCLES(1), .MISS_TIMEOUT(4), .CNT_W(4)) dut_a (
        .CLK   (clk),
        .RESET (rst),
        .bus   (if_a)
    );

    ifid_hazard_ctrl #(.LOAD_USE_CYCLES(2), .MISS_TIMEOUT(255), .CNT_W(32)) dut_b (
        .CLK   (clk),
        .RESET (rst),
        .bus   (if_b)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    task automatic clr_in();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        br_valid = 1'b0; br_mispredict = 1'b0; br_target = '0;
        ic_miss = 1'b0; ic_ready = 1'b0; dmem_busy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        clr_in();
        rst = 1'b1;
        #2;
        chk("rst_stall_pc",  32'(if_a.STALL_PC), 32'd0);
        chk("rst_flush",     32'(if_a.FLUSH_IFID), 32'd0);
        chk("rst_err",       32'(if_a.Miss_Timeout_ERR), 32'd0);
        chk("rst_redirect",  if_a.PC_Redirect, 32'd0);
        chk("rst_stall_cnt", 32'(if_b.Stall_Count), 32'd0);
        chk("rst_state",     32'(if_a.fsm_state), 32'(RUN));
        tick();
        rst = 1'b0;

        // ---- 1: load-use on Rs, one bubble cycle (dut_a) ----
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        #1;
        chk("lu_stall_pc",   32'(if_a.STALL_PC), 32'd1);
        chk("lu_stall_ifid", 32'(if_a.STALL_IFID), 32'd1);
        chk("lu_bubble",     32'(if_a.BUBBLE_IDEX), 32'd1);
        chk("lu_flush",      32'(if_a.FLUSH_IFID), 32'd0);
        tick();
        clr_in();
        #1;
        chk("lu_one_cycle",  32'(if_a.STALL_PC), 32'd0);
        chk("lu_stall_cnt",  32'(if_a.Stall_Count), 32'd1);
        // EX_Rd = r0 is never a hazard
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #1;
        chk("lu_r0_nostall", 32'(if_a.STALL_PC), 32'd0);
        // Rt path, then same register but operand not read
        clr_in();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
        #1;
        chk("lu_rt_bubble",  32'(if_a.BUBBLE_IDEX), 32'd1);
        id_uses_rt = 1'b0;
        #1;
        chk("lu_rt_unused",  32'(if_a.BUBBLE_IDEX), 32'd0);
        clr_in();

        // ---- 2: mispredict during IMISS (dut_a) ----
        do_reset();
        ic_miss = 1'b1;
        #1;
        chk("im_entry_stall_pc",   32'(if_a.STALL_PC), 32'd1);
        chk("im_entry_flush",      32'(if_a.FLUSH_IFID), 32'd1);
        chk("im_entry_stall_ifid", 32'(if_a.STALL_IFID), 32'd0);
        tick();
        ic_miss = 1'b0;
        chk("im_state", 32'(if_a.fsm_state), 32'(IMISS));
        tick(); tick(); tick();
        br_valid = 1'b1; br_mispredict = 1'b1; br_target = 32'h0040_0020;
        ic_ready = 1'b1;
        #1;
        chk("mp_flush",      32'(if_a.FLUSH_IFID), 32'd1);
        chk("mp_redir_v",    32'(if_a.PC_Redirect_Valid), 32'd1);
        chk("mp_redir",      if_a.PC_Redirect, 32'h0040_0020);
        chk("mp_stall_pc",   32'(if_a.STALL_PC), 32'd0);
        chk("mp_stall_ifid", 32'(if_a.STALL_IFID), 32'd0);
        chk("mp_bubble",     32'(if_a.BUBBLE_IDEX), 32'd1);
        tick();
        clr_in();
        #1;
        chk("mp_state_run",  32'(if_a.fsm_state), 32'(RUN));
        chk("mp_after_flush", 32'(if_a.FLUSH_IFID), 32'd0);
        chk("mp_after_redir", 32'(if_a.PC_Redirect_Valid), 32'd0);
        chk("mp_no_err",     32'(if_a.Miss_Timeout_ERR), 32'd0);
        chk("mp_flush_cnt",  32'(if_a.Flush_Count), 32'd5);
        chk("mp_stall_cnt",  32'(if_a.Stall_Count), 32'd4);

        // ---- 3: miss timeout, MISS_TIMEOUT=4 (dut_a) ----
        do_reset();
        ic_miss = 1'b1;
        tick();
        ic_miss = 1'b0;
        tick(); tick(); tick();
        chk("to_err_after3", 32'(if_a.Miss_Timeout_ERR), 32'd0);
        tick();
        chk("to_err_after4", 32'(if_a.Miss_Timeout_ERR), 32'd1);
        tick(); tick();
        chk("to_err_after6", 32'(if_a.Miss_Timeout_ERR), 32'd1);
        chk("to_state",      32'(if_a.fsm_state), 32'(IMISS));
        chk("to_stall_pc",   32'(if_a.STALL_PC), 32'd1);
        ic_ready = 1'b1;
        #1;
        chk("rdy_stall_pc",  32'(if_a.STALL_PC), 32'd0);
        chk("rdy_flush",     32'(if_a.FLUSH_IFID), 32'd0);
        tick();
        clr_in();
        #1;
        chk("rdy_state_run", 32'(if_a.fsm_state), 32'(RUN));
        chk("rdy_err_kept",  32'(if_a.Miss_Timeout_ERR), 32'd1);
        chk("to_stall_cnt",  32'(if_a.Stall_Count), 32'd7);
        chk("to_flush_cnt",  32'(if_a.Flush_Count), 32'd7);

        // ---- 5: async reset mid-IMISS (dut_a) ----
        do_reset();
        ic_miss = 1'b1;
        tick();
        ic_miss = 1'b0;
        tick(); tick();
        chk("ar_pre_cnt",    32'(if_a.Stall_Count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_stall_pc",   32'(if_a.STALL_PC), 32'd0);
        chk("ar_flush",      32'(if_a.FLUSH_IFID), 32'd0);
        chk("ar_stall_cnt",  32'(if_a.Stall_Count), 32'd0);
        chk("ar_flush_cnt",  32'(if_a.Flush_Count), 32'd0);
        chk("ar_state",      32'(if_a.fsm_state), 32'(RUN));
        #1;
        rst = 1'b0;
        tick();
        chk("ar_next_state", 32'(if_a.fsm_state), 32'(RUN));
        chk("ar_next_stall", 32'(if_a.STALL_PC), 32'd0);

        // ---- 4: DMEM_Busy freeze with load-use, LOAD_USE_CYCLES=2 (dut_b) ----
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        dmem_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("frz_stall_pc", 32'(if_b.STALL_PC), 32'd1);
            chk("frz_bubble",   32'(if_b.BUBBLE_IDEX), 32'd0);
            chk("frz_state",    32'(if_b.fsm_state), 32'(RUN));
            tick();
        end
        dmem_busy = 1'b0;
        #1;
        chk("lu2_c0_bubble", 32'(if_b.BUBBLE_IDEX), 32'd1);
        chk("lu2_c0_stall",  32'(if_b.STALL_IFID), 32'd1);
        tick();
        clr_in();
        #1;
        chk("lu2_c1_state",  32'(if_b.fsm_state), 32'(LOAD_USE));
        chk("lu2_c1_bubble", 32'(if_b.BUBBLE_IDEX), 32'd1);
        chk("lu2_c1_stall",  32'(if_b.STALL_PC), 32'd1);
        tick();
        chk("lu2_done_state",  32'(if_b.fsm_state), 32'(RUN));
        chk("lu2_done_bubble", 32'(if_b.BUBBLE_IDEX), 32'd0);
        chk("lu2_stall_cnt",   if_b.Stall_Count, 32'd5);

        // ---- 6: counter saturation, CNT_W=4 (dut_a) ----
        do_reset();
        dmem_busy = 1'b1;
        repeat (20) tick();
        chk("sat_stall_cnt", 32'(if_a.Stall_Count), 32'd15);
        tick();
        chk("sat_hold",      32'(if_a.Stall_Count), 32'd15);
        chk("sat_flush_cnt", 32'(if_a.Flush_Count), 32'd0);
        chk("sat_wide_cnt",  if_b.Stall_Count, 32'd21);
        clr_in();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
